// File: rtl/debug_step_controller.sv
// debug_step_controller: host command sequencer for the MIPS debug port.
// Optional DEBUG_AUTO_DUMP_EN: a successful step/run is followed by a full dump instead of an ack.
module debug_step_controller #(
  parameter int NB              = 32,
  parameter int N_REGS          = 32,
  parameter int TAM_DATA_MEMORY = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_step,
  output logic [4:0]    o_debug_register_number,
  output logic [NB-1:0] o_debug_address,
  input  logic [NB-1:0] i_mips_pc,
  input  logic [NB-1:0] i_mips_alu_result,
  input  logic [NB-1:0] i_mips_register_data,
  input  logic [NB-1:0] i_mips_data_memory,
  input  logic          i_mips_halt
);

  localparam int WORDS = 2 + N_REGS + TAM_DATA_MEMORY;
  localparam int IW    = $clog2(WORDS);

  localparam logic [IW-1:0] IDX_ALU  = IW'(1);
  localparam logic [IW-1:0] IDX_REG0 = IW'(2);
  localparam logic [IW-1:0] IDX_MEM0 = IW'(2 + N_REGS);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    RUN,
    DUMP_SET,
    DUMP_LOAD,
    DUMP_SEND,
    RESP
  } state_e;

  state_e        state_q;
  logic          step_q;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;
  logic [4:0]    reg_num_q;
  logic [NB-1:0] addr_q;
  logic [IW-1:0] idx_q;
  logic [NB-1:0] shift_q;
  logic [1:0]    byte_q;

  logic          rx_fire;
  logic          tx_fire;
  logic          run_exit;
  logic          is_pc;
  logic          is_alu;
  logic          is_reg;
  logic          is_mem;
  logic [IW-1:0] reg_off;
  logic [IW-1:0] mem_off;
  logic [IW-1:0] idx_d;
  logic [NB-1:0] shift_d;
  logic [NB-1:0] word_sel;

  assign o_rx_ready = (state_q == IDLE) || (state_q == RUN);
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_step     = step_q;
  assign o_debug_register_number = reg_num_q;
  assign o_debug_address         = addr_q;

  assign rx_fire  = i_rx_valid & o_rx_ready;
  assign tx_fire  = tx_valid_q & i_tx_ready;
  assign run_exit = i_mips_halt | (rx_fire & (i_rx_data == CMD_HALT));

  assign is_pc   = (idx_q == '0);
  assign is_alu  = (idx_q == IDX_ALU);
  assign is_reg  = (idx_q >= IDX_REG0) && (idx_q < IDX_MEM0);
  assign is_mem  = (idx_q >= IDX_MEM0);
  assign reg_off = idx_q - IDX_REG0;
  assign mem_off = idx_q - IDX_MEM0;
  assign idx_d   = idx_q + IW'(1);
  assign shift_d = shift_q << 8;

  // Pick the pipeline debug word addressed by the current dump index.
  always_comb begin
    word_sel = '0;
    unique case (1'b1)
      is_pc:   word_sel = i_mips_pc;
      is_alu:  word_sel = i_mips_alu_result;
      is_reg:  word_sel = i_mips_register_data;
      is_mem:  word_sel = i_mips_data_memory;
      default: word_sel = '0;
    endcase
  end

  // Command sequencer with registered step, response and debug-select outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      step_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      reg_num_q  <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rx_fire) begin
            unique case (i_rx_data)
              CMD_STEP, CMD_RUN: begin
                if (i_mips_halt) begin
                  tx_data_q  <= RSP_NAK;
                  tx_valid_q <= 1'b1;
                  state_q    <= RESP;
                end else if (i_rx_data == CMD_STEP) begin
                  state_q <= STEP;
                end else begin
                  state_q <= RUN;
                end
              end
              CMD_DUMP: begin
                idx_q   <= '0;
                state_q <= DUMP_SET;
              end
              default: begin
                tx_data_q  <= RSP_ERR;
                tx_valid_q <= 1'b1;
                state_q    <= RESP;
              end
            endcase
          end
        end

        // First cycle raises the step, second drops it and completes.
        STEP: begin
          if (!step_q) begin
            step_q <= 1'b1;
          end else begin
            step_q <= 1'b0;
`ifdef DEBUG_AUTO_DUMP_EN
            idx_q   <= '0;
            state_q <= DUMP_SET;
`else
            tx_data_q  <= RSP_ACK;
            tx_valid_q <= 1'b1;
            state_q    <= RESP;
`endif
          end
        end

        // Halt is checked before each step so the pipeline never overshoots.
        RUN: begin
          if (run_exit) begin
            step_q <= 1'b0;
`ifdef DEBUG_AUTO_DUMP_EN
            idx_q   <= '0;
            state_q <= DUMP_SET;
`else
            tx_data_q  <= RSP_ACK;
            tx_valid_q <= 1'b1;
            state_q    <= RESP;
`endif
          end else begin
            step_q <= 1'b1;
          end
        end

        // Point the pipeline read ports at the word; data settles next cycle.
        DUMP_SET: begin
          if (is_reg) begin
            reg_num_q <= 5'(reg_off);
          end
          if (is_mem) begin
            addr_q <= NB'({mem_off, 2'b00});
          end
          state_q <= DUMP_LOAD;
        end

        DUMP_LOAD: begin
          shift_q    <= word_sel;
          tx_data_q  <= word_sel[NB-1 -: 8];
          tx_valid_q <= 1'b1;
          byte_q     <= '0;
          state_q    <= DUMP_SEND;
        end

        DUMP_SEND: begin
          if (tx_fire) begin
            if (byte_q == 2'd3) begin
              tx_valid_q <= 1'b0;
              if (idx_q == IDX_LAST) begin
                idx_q   <= '0;
                state_q <= IDLE;
              end else begin
                idx_q   <= idx_d;
                state_q <= DUMP_SET;
              end
            end else begin
              shift_q   <= shift_d;
              tx_data_q <= shift_d[NB-1 -: 8];
              byte_q    <= byte_q + 2'd1;
            end
          end
        end

        RESP: begin
          if (tx_fire) begin
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end

        default: begin
          step_q     <= 1'b0;
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_step_controller.sv
// tb_debug_step_controller: directed vectors and dump sequences.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_debug_step_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        step;
  logic [4:0]  reg_num;
  logic [31:0] dbg_addr;
  logic [31:0] pc = 32'h0000_0018;
  logic [31:0] alu = 32'hA5A5_1234;
  logic [31:0] reg_data;
  logic [31:0] mem_data;
  logic        halt = 1'b0;
  logic        mem_zero = 1'b1;

  int nvec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] reg_model(input int n);
    if (n == 7) return 32'hFFFF_FBF9;
    return {8'h0A, 3'b000, 5'(n), 8'h5C, 3'b000, 5'(n)};
  endfunction

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (mem_zero) return 32'h0;
    return a ^ 32'hC0DE_0000;
  endfunction

  assign reg_data = reg_model(int'(reg_num));
  assign mem_data = mem_model(dbg_addr);

  debug_step_controller dut (
    .i_clk                   (clk),
    .i_reset                 (rst_n),
    .i_rx_data               (rx_data),
    .i_rx_valid              (rx_valid),
    .o_rx_ready              (rx_ready),
    .o_tx_data               (tx_data),
    .o_tx_valid              (tx_valid),
    .i_tx_ready              (tx_ready),
    .o_step                  (step),
    .o_debug_register_number (reg_num),
    .o_debug_address         (dbg_addr),
    .i_mips_pc               (pc),
    .i_mips_alu_result       (alu),
    .i_mips_register_data    (reg_data),
    .i_mips_data_memory      (mem_data),
    .i_mips_halt             (halt)
  );

  typedef struct {
    logic [7:0] cmd;
    logic       halt;
    int         hd;
    int         steps;
    logic [7:0] resp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic take_resp();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int k, output int steps);
    int c = 0;
    steps = 0;
    halt = v.halt;
    send(v.cmd);
    while (!tx_valid && c < 300) begin
      if (step) steps++;
      @(negedge clk);
      c++;
      if (v.hd != 0 && c == v.hd) halt = 1'b1;
    end
    chk($sformatf("v%0d_steps", k), 32'(steps), 32'(v.steps));
    chk($sformatf("v%0d_resp", k), {24'h0, tx_data}, {24'h0, v.resp});
    take_resp();
    halt = 1'b0;
    chk($sformatf("v%0d_idle", k), {31'h0, tx_valid}, 32'd0);
  endtask

  task automatic quiet_check(input string name);
    int seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (tx_valid || step) seen++;
      @(negedge clk);
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  function automatic logic [31:0] word_model(input int w);
    if (w == 0) return pc;
    if (w == 1) return alu;
    if (w < 34) return reg_model(w - 2);
    return mem_model(32'((w - 34) * 4));
  endfunction

  task automatic dump(input int abort_at, input bit toggle,
                      input bit zero_mem, output int last_g);
    int cnt = 0;
    int g = 0;
    bit pend = 0;
    logic [7:0] pd;
    logic [31:0] w;
    logic [7:0] ex;
    last_g = -1;
    mem_zero = zero_mem;
    send(8'h44);
    while (cnt < 200 && g < 4000) begin
      if (pend) chk("hold_data", {24'h0, tx_data}, {24'h0, pd});
      if (cnt == abort_at) begin
        tx_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_txv", {31'h0, tx_valid}, 32'd0);
        chk("mid_rst_txd", {24'h0, tx_data}, 32'd0);
        chk("mid_rst_reg", {27'h0, reg_num}, 32'd0);
        chk("mid_rst_rdy", {31'h0, rx_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      tx_ready = toggle ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (tx_valid) begin
        if (tx_ready) begin
          w  = word_model(cnt / 4);
          ex = w[31 - 8 * (cnt % 4) -: 8];
          chk($sformatf("dump_b%0d", cnt), {24'h0, tx_data}, {24'h0, ex});
          cnt++;
          pend = 0;
          last_g = g;
        end else begin
          pend = 1;
          pd = tx_data;
        end
      end else begin
        pend = 0;
      end
      @(negedge clk);
      g++;
    end
    tx_ready = 1'b0;
    if (cnt < 200) chk("dump_timeout", 32'(cnt), 32'd200);
  endtask

  initial begin
    int steps;
    int tot_s = 0;
    int lg;

    tbl[0] = '{8'h53, 1'b0, 0, 1, 8'h06};
    tbl[1] = '{8'h53, 1'b0, 0, 1, 8'h06};
    tbl[2] = '{8'h53, 1'b0, 0, 1, 8'h06};
    tbl[3] = '{8'h52, 1'b0, 10, 10, 8'h06};
    tbl[4] = '{8'h52, 1'b1, 0, 0, 8'h15};
    tbl[5] = '{8'h53, 1'b1, 0, 0, 8'h15};
    tbl[6] = '{8'h7A, 1'b0, 0, 0, 8'h45};
    tbl[7] = '{8'h48, 1'b0, 0, 0, 8'h45};
    tbl[8] = '{8'h52, 1'b0, 3, 3, 8'h06};
    tbl[9] = '{8'h52, 1'b0, 1, 1, 8'h06};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_step", {31'h0, step}, 32'd0);
    chk("rst_txv", {31'h0, tx_valid}, 32'd0);
    chk("rst_txd", {24'h0, tx_data}, 32'd0);
    chk("rst_rdy", {31'h0, rx_ready}, 32'd1);
    chk("rst_sel", {27'h0, reg_num} | dbg_addr, 32'd0);

    for (int k = 0; k < 10; k++) begin
      run_vec(tbl[k], k, steps);
      if (k < 3) tot_s += steps;
    end
    chk("s_total", 32'(tot_s), 32'd3);

    send(8'h52);
    repeat (3) @(negedge clk);
    send(8'h7A);
    repeat (2) @(negedge clk);
    chk("run_discard", {31'h0, step}, 32'd1);
    send(8'h48);
    chk("run_h_txv", {31'h0, tx_valid}, 32'd1);
    chk("run_h_resp", {24'h0, tx_data}, 32'h06);
    take_resp();
    quiet_check("run_h_single");

    send(8'h52);
    repeat (3) @(negedge clk);
    halt = 1'b1;
    rx_data = 8'h48;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("both_txv", {31'h0, tx_valid}, 32'd1);
    chk("both_resp", {24'h0, tx_data}, 32'h06);
    chk("both_step", {31'h0, step}, 32'd0);
    take_resp();
    halt = 1'b0;
    quiet_check("both_single");

    dump(1000, 1'b1, 1'b1, lg);
    quiet_check("dump_no_ack");
    chk("dump_rdy", {31'h0, rx_ready}, 32'd1);

    dump(37, 1'b1, 1'b1, lg);
    quiet_check("rst_quiet");

    dump(1000, 1'b0, 1'b0, lg);
    chk("dump_cycles", 32'(lg), 32'd299);
    quiet_check("dump2_no_ack");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
